// File: rtl/pu_msp430_ram_arb_pkg.sv
// Shared types and constants for the MSP430 RAM port arbiter.
package pu_msp430_ram_arb_pkg;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  localparam logic [1:0] WEN_READ = 2'b11;
  localparam logic [1:0] WEN_WORD = 2'b00;

  typedef struct packed {
    logic     valid;
    logic     is_read;
    logic     oob;
    req_idx_t owner;
  } rsp_pipe_t;

  function automatic logic is_read_access(input logic [1:0] wen);
    return wen == WEN_READ;
  endfunction

  function automatic logic is_word_write(input logic [1:0] wen);
    return wen == WEN_WORD;
  endfunction

endpackage

// File: rtl/pu_msp430_rr_arbiter_2.sv
// Two-way grant logic: round-robin on ties, or fixed priority to requester 0
// with an external starvation override.
module pu_msp430_rr_arbiter_2
  import pu_msp430_ram_arb_pkg::*;
(
  input  logic mclk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic fixed_mode,
  input  logic starve_force,
  output logic gnt0,
  output logic gnt1
);

  req_idx_t last_win;
  logic     pick1;

  always_comb begin
    pick1 = 1'b0;
    if (req1 && !req0)
      pick1 = 1'b1;
    else if (req0 && req1)
      pick1 = fixed_mode ? starve_force : (last_win == REQ0);
    gnt1 = req1 && pick1;
    gnt0 = req0 && !pick1;
  end

  // Reset as if requester 1 won last, so requester 0 takes the first tie.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      last_win <= REQ1;
    else if (gnt0 || gnt1)
      last_win <= gnt1 ? REQ1 : REQ0;
  end

endmodule

// File: rtl/pu_msp430_ram_arbiter.sv
// Shares one MSP430 word-RAM port between the CPU backbone (0) and a DMA/debug
// master (1); routes read data and range errors back to the access owner.
module pu_msp430_ram_arbiter
  import pu_msp430_ram_arb_pkg::*;
#(
  parameter int ADDR_MSB     = 6,
  parameter int MEM_SIZE     = 256,
  parameter int FIXED_PRIO   = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_MSB:0] addr0,
  input  logic [ADDR_MSB:0] addr1,
  input  logic [1:0]        wen0,
  input  logic [1:0]        wen1,
  input  logic [15:0]       din0,
  input  logic [15:0]       din1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [15:0]       rdata0,
  output logic [15:0]       rdata1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_MSB:0] ram_addr,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout
);

  localparam int         WORDS     = MEM_SIZE / 2;
  localparam logic [3:0] STARVE_TC = 4'(STARVE_LIMIT);

  logic       starve_force;
  logic [3:0] starve_left;
  logic       in_range;
  rsp_pipe_t  pipe_d, pipe_q;
  logic [15:0] rd_data;

  pu_msp430_rr_arbiter_2 u_arb (
    .mclk         (mclk),
    .reset_n      (reset_n),
    .req0         (req0),
    .req1         (req1),
    .fixed_mode   (FIXED_PRIO != 0),
    .starve_force (starve_force),
    .gnt0         (gnt0),
    .gnt1         (gnt1)
  );

  // Down-counts the cycles requester 1 may still lose; terminal count forces its grant.
  assign starve_force = (starve_left == 4'd0);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      starve_left <= STARVE_TC;
    else if (req1 && !gnt1)
      starve_left <= starve_force ? 4'd0 : starve_left - 4'd1;
    else
      starve_left <= STARVE_TC;
  end

  always_comb begin
    ram_addr = '0;
    ram_wen  = WEN_READ;
    ram_din  = '0;
    if (gnt0) begin
      ram_addr = addr0;
      ram_wen  = wen0;
      ram_din  = din0;
    end else if (gnt1) begin
      ram_addr = addr1;
      ram_wen  = wen1;
      ram_din  = din1;
    end
  end

  assign in_range = (int'(ram_addr) < WORDS);
  assign ram_cen  = !((gnt0 || gnt1) && in_range);

  always_comb begin
    pipe_d         = '0;
    pipe_d.valid   = gnt0 || gnt1;
    pipe_d.is_read = is_read_access(ram_wen);
    pipe_d.oob     = !in_range;
    pipe_d.owner   = gnt1 ? REQ1 : REQ0;
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n)
      pipe_q <= '0;
    else
      pipe_q <= pipe_d;
  end

  // Out-of-range reads never touched the RAM, so return zero instead of stale dout.
  assign rd_data = pipe_q.oob ? 16'h0000 : ram_dout;

  assign rvalid0 = pipe_q.valid && pipe_q.is_read && (pipe_q.owner == REQ0);
  assign rvalid1 = pipe_q.valid && pipe_q.is_read && (pipe_q.owner == REQ1);
  assign rdata0  = rvalid0 ? rd_data : 16'h0000;
  assign rdata1  = rvalid1 ? rd_data : 16'h0000;
  assign err0    = pipe_q.valid && pipe_q.oob && (pipe_q.owner == REQ0);
  assign err1    = pipe_q.valid && pipe_q.oob && (pipe_q.owner == REQ1);

endmodule

// File: tb/tb_pu_msp430_ram_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus;
// a reference model predicts grants, RAM port and queued responses.
module tb_pu_msp430_ram_arbiter;

  localparam int AMSB  = 7;
  localparam int MSIZE = 256;
  localparam int WORDS = MSIZE / 2;
  localparam int LIM   = 4;

  typedef struct packed {
    logic        v0;
    logic [15:0] d0;
    logic        v1;
    logic [15:0] d1;
    logic        e0;
    logic        e1;
  } resp_t;

  logic            mclk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req0 = 1'b0, req1 = 1'b0;
  logic [AMSB:0]   addr0 = '0, addr1 = '0;
  logic [1:0]      wen0 = 2'b11, wen1 = 2'b11;
  logic [15:0]     din0 = '0, din1 = '0;

  logic            gnt0_rr, gnt1_rr, rvalid0_rr, rvalid1_rr, err0_rr, err1_rr, ram_cen_rr;
  logic [15:0]     rdata0_rr, rdata1_rr, ram_din_rr, ram_dout_rr;
  logic [AMSB:0]   ram_addr_rr;
  logic [1:0]      ram_wen_rr;
  logic            gnt0_fx, gnt1_fx, rvalid0_fx, rvalid1_fx, err0_fx, err1_fx, ram_cen_fx;
  logic [15:0]     rdata0_fx, rdata1_fx, ram_din_fx, ram_dout_fx;
  logic [AMSB:0]   ram_addr_fx;
  logic [1:0]      ram_wen_fx;

  logic [15:0]     mem_rr [WORDS];
  logic [15:0]     mem_fx [WORDS];
  logic [15:0]     model_mem [WORDS];
  logic            last_rr = 1'b1;
  int              starve = 0;
  resp_t           sb_rr[$];
  resp_t           sb_fx[$];
  int              n_vec = 0;
  int              n_err = 0;

  always #5 mclk = ~mclk;

  pu_msp430_ram_arbiter #(.ADDR_MSB(AMSB), .MEM_SIZE(MSIZE), .FIXED_PRIO(0), .STARVE_LIMIT(LIM)) dut_rr (
    .mclk(mclk), .reset_n(reset_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wen0(wen0), .wen1(wen1), .din0(din0), .din1(din1), .gnt0(gnt0_rr), .gnt1(gnt1_rr),
    .rdata0(rdata0_rr), .rdata1(rdata1_rr), .rvalid0(rvalid0_rr), .rvalid1(rvalid1_rr),
    .err0(err0_rr), .err1(err1_rr), .ram_addr(ram_addr_rr), .ram_cen(ram_cen_rr),
    .ram_wen(ram_wen_rr), .ram_din(ram_din_rr), .ram_dout(ram_dout_rr)
  );

  pu_msp430_ram_arbiter #(.ADDR_MSB(AMSB), .MEM_SIZE(MSIZE), .FIXED_PRIO(1), .STARVE_LIMIT(LIM)) dut_fx (
    .mclk(mclk), .reset_n(reset_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wen0(wen0), .wen1(wen1), .din0(din0), .din1(din1), .gnt0(gnt0_fx), .gnt1(gnt1_fx),
    .rdata0(rdata0_fx), .rdata1(rdata1_fx), .rvalid0(rvalid0_fx), .rvalid1(rvalid1_fx),
    .err0(err0_fx), .err1(err1_fx), .ram_addr(ram_addr_fx), .ram_cen(ram_cen_fx),
    .ram_wen(ram_wen_fx), .ram_din(ram_din_fx), .ram_dout(ram_dout_fx)
  );

  // Synchronous word RAMs with active-low byte enables and registered read.
  always @(posedge mclk) begin
    if (!ram_cen_rr) begin
      if (ram_wen_rr == 2'b11) ram_dout_rr <= mem_rr[ram_addr_rr[6:0]];
      else begin
        if (!ram_wen_rr[0]) mem_rr[ram_addr_rr[6:0]][7:0]  <= ram_din_rr[7:0];
        if (!ram_wen_rr[1]) mem_rr[ram_addr_rr[6:0]][15:8] <= ram_din_rr[15:8];
      end
    end
  end

  always @(posedge mclk) begin
    if (!ram_cen_fx) begin
      if (ram_wen_fx == 2'b11) ram_dout_fx <= mem_fx[ram_addr_fx[6:0]];
      else begin
        if (!ram_wen_fx[0]) mem_fx[ram_addr_fx[6:0]][7:0]  <= ram_din_fx[7:0];
        if (!ram_wen_fx[1]) mem_fx[ram_addr_fx[6:0]][15:8] <= ram_din_fx[15:8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] exp_ram(input logic g0, input logic g1);
    logic [AMSB:0] a;
    logic [1:0]    w;
    logic [15:0]   d;
    logic          cen;
    a = '0; w = 2'b11; d = '0; cen = 1'b1;
    if (g0) begin a = addr0; w = wen0; d = din0; end
    else if (g1) begin a = addr1; w = wen1; d = din1; end
    if ((g0 || g1) && int'(a) < WORDS) cen = 1'b0;
    return {a, w, d, cen};
  endfunction

  function automatic resp_t exp_resp(input logic g0, input logic g1);
    resp_t         r;
    logic [AMSB:0] a;
    logic [1:0]    w;
    logic          oob;
    logic [15:0]   d;
    r = '0;
    if (g0 || g1) begin
      a   = g0 ? addr0 : addr1;
      w   = g0 ? wen0 : wen1;
      oob = int'(a) >= WORDS;
      d   = oob ? 16'h0000 : model_mem[a[6:0]];
      if (g0) begin
        r.v0 = (w == 2'b11); r.d0 = (w == 2'b11) ? d : 16'h0000; r.e0 = oob;
      end else begin
        r.v1 = (w == 2'b11); r.d1 = (w == 2'b11) ? d : 16'h0000; r.e1 = oob;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic r0, input logic [AMSB:0] a0, input logic [1:0] w0, input logic [15:0] d0,
                       input logic r1, input logic [AMSB:0] a1, input logic [1:0] w1, input logic [15:0] d1);
    req0 = r0; addr0 = a0; wen0 = w0; din0 = d0;
    req1 = r1; addr1 = a1; wen1 = w1; din1 = d1;
  endtask

  task automatic run_cycle();
    logic g0r, g1r, g0f, g1f;
    logic [AMSB:0] a;
    logic [1:0]    w;
    logic [15:0]   d;
    resp_t         er, ef;
    @(negedge mclk);
    if (req0 && req1) begin g0r = last_rr; g1r = !last_rr; end
    else begin g0r = req0; g1r = req1; end
    g1f = req1 && (!req0 || starve == LIM);
    g0f = req0 && !g1f;
    check("gnt_rr", 64'({gnt0_rr, gnt1_rr}), 64'({g0r, g1r}));
    check("gnt_fx", 64'({gnt0_fx, gnt1_fx}), 64'({g0f, g1f}));
    check("ram_rr", 64'({ram_addr_rr, ram_wen_rr, ram_din_rr, ram_cen_rr}), 64'(exp_ram(g0r, g1r)));
    check("ram_fx", 64'({ram_addr_fx, ram_wen_fx, ram_din_fx, ram_cen_fx}), 64'(exp_ram(g0f, g1f)));
    sb_rr.push_back(exp_resp(g0r, g1r));
    sb_fx.push_back(exp_resp(g0f, g1f));
    if (g0r || g1r) begin
      a = g0r ? addr0 : addr1;
      w = g0r ? wen0 : wen1;
      d = g0r ? din0 : din1;
      if (w != 2'b11 && int'(a) < WORDS) begin
        if (!w[0]) model_mem[a[6:0]][7:0]  = d[7:0];
        if (!w[1]) model_mem[a[6:0]][15:8] = d[15:8];
      end
      last_rr = g1r;
    end
    if (req1 && !g1f) starve = (starve == LIM) ? LIM : starve + 1;
    else starve = 0;
    @(posedge mclk);
    #1;
    er = sb_rr.pop_front();
    ef = sb_fx.pop_front();
    check("rsp_rr", 64'({rvalid0_rr, rdata0_rr, rvalid1_rr, rdata1_rr, err0_rr, err1_rr}), 64'(er));
    check("rsp_fx", 64'({rvalid0_fx, rdata0_fx, rvalid1_fx, rdata1_fx, err0_fx, err1_fx}), 64'(ef));
  endtask

  initial begin
    for (int i = 0; i < WORDS; i++) model_mem[i] = 16'h0000;
    #1;
    check("rst_rsp_rr", 64'({rvalid0_rr, rvalid1_rr, err0_rr, err1_rr}), 64'(0));
    check("rst_rsp_fx", 64'({rvalid0_fx, rvalid1_fx, err0_fx, err1_fx}), 64'(0));
    check("rst_ram_rr", 64'({ram_addr_rr, ram_wen_rr, ram_din_rr, ram_cen_rr}), 64'(exp_ram(1'b0, 1'b0)));
    #11 reset_n = 1'b1;
    @(posedge mclk);
    #1;

    // Preload through the arbiter, then single read/write traffic
    drive(1, 8'd5, 2'b00, 16'hA55A, 0, 8'd0, 2'b11, 16'h0);    run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0,    1, 8'd3, 2'b00, 16'h0034); run_cycle();
    drive(1, 8'd5, 2'b11, 16'h0,    0, 8'd0, 2'b11, 16'h0);    run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0,    1, 8'd3, 2'b11, 16'h0);    run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0,    0, 8'd0, 2'b11, 16'h0);    run_cycle();

    // Sustained contention: alternation in one instance, starvation bound in the other
    drive(1, 8'd5, 2'b11, 16'h0, 1, 8'd3, 2'b11, 16'h0);
    for (int i = 0; i < 10; i++) run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0, 0, 8'd0, 2'b11, 16'h0);       run_cycle();

    // Byte writes, out-of-range accesses, read-back
    drive(0, 8'd0, 2'b11, 16'h0,    1, 8'd3,   2'b01, 16'h12FF); run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0,    1, 8'd3,   2'b11, 16'h0);    run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0,    1, 8'd200, 2'b00, 16'hDEAD); run_cycle();
    drive(1, 8'd128, 2'b11, 16'h0,  0, 8'd0,   2'b11, 16'h0);    run_cycle();
    drive(1, 8'd5, 2'b10, 16'h00BB, 0, 8'd0,   2'b11, 16'h0);    run_cycle();
    drive(1, 8'd5, 2'b11, 16'h0,    0, 8'd0,   2'b11, 16'h0);    run_cycle();

    // Reset lands between a read grant and its response
    drive(1, 8'd5, 2'b11, 16'h0, 0, 8'd0, 2'b11, 16'h0);
    @(negedge mclk);
    check("gnt_pre_rst", 64'({gnt0_rr, gnt1_rr}), 64'(2'b10));
    #2 reset_n = 1'b0;
    @(posedge mclk);
    #1;
    check("rsp_lost_rr", 64'({rvalid0_rr, err0_rr, rvalid1_rr}), 64'(0));
    check("rsp_lost_fx", 64'({rvalid0_fx, err0_fx, rvalid1_fx}), 64'(0));
    last_rr = 1'b1;
    starve  = 0;
    #2 reset_n = 1'b1;
    drive(1, 8'd5, 2'b11, 16'h0, 1, 8'd3, 2'b11, 16'h0); run_cycle();
    drive(0, 8'd0, 2'b11, 16'h0, 0, 8'd0, 2'b11, 16'h0); run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
